alu_portb_sr: RTL and testbench
===============================

Name: alu_portb_sr

Overview:
- ALU Port B register rebuilt as a synchronous shift register plus the L (link) flag. It sits directly downstream of the serial Shift/Rotate Unit and consumes its per-step shift strobes.
- Port B is loaded from the IBus, shifted or rotated one bit per strobe, and read back onto the IBus by the microcode.
- It replaces the separate Port B latch and the discrete L flip-flop in the SRU datapath, so every shift step becomes a clocked, single-edge event.

Parameters:
- WIDTH, 16, data width of Port B and IBus.
- CNTW, 5, width of the diagnostic step counter; saturates at 2^CNTW-1.

Ports:
- clk2  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- ibus_in  in  WIDTH  IBus data for loading.
- nwrite_alu  in  1  active-low load strobe, sampled on clk2.
- nstart  in  1  active-low SRU start, sampled on clk2; clears L and the step counter.
- shift_en  in  1  one-cycle shift-step strobe from the SRU.
- op_rotate  in  1  operation bit: rotate.
- op_arithmetic  in  1  operation bit: arithmetic.
- op_right  in  1  operation bit: right.
- nread_alu_b  in  1  active-low IBus read enable.
- b  out  WIDTH  Port B register contents, to the ALU.
- fl  out  1  L flag.
- ibus_out  out  WIDTH  IBus drive data; equals b.
- ibus_oe  out  1  IBus output enable, equal to !nread_alu_b (combinational).
- steps  out  CNTW  shift steps taken since the last nstart.
- collide  out  1  registered one-cycle pulse when shift_en is dropped.

Behaviour:
- Reset (asynchronous): b=0, fl=0, steps=0, collide=0. While reset is high, all strobes are ignored.
- Per-edge priority, highest first:
  1. load (nwrite_alu=0): b<=ibus_in; fl and steps unchanged.
  2. start (nstart=0): fl<=0, steps<=0; b unchanged unless load is also active.
  3. shift (shift_en=1): one step as below.
- If shift_en is high in the same cycle as load or start, the shift is suppressed and collide<=1 for one cycle. Otherwise collide<=0.
- Latency: one clk2 edge from strobe to new b/fl; b, fl and steps are all registered.
- One shift step, by op {rotate,arithmetic,right}, old values b and fl:
  - 000 SHL, and 010: b<={b[14:0],0}; fl<=b[15].
  - 001 SHR: b<={0,b[15:1]}; fl<=b[0].
  - 011 ASR: b<={b[15],b[15:1]}; fl<=b[0].
  - 100 ROL through L (17-bit): b<={b[14:0],fl}; fl<=b[15].
  - 101 ROR through L (17-bit): b<={fl,b[15:1]}; fl<=b[0].
  - 110 ROL 16-bit: b<={b[14:0],b[15]}; fl<=b[15].
  - 111 ROR 16-bit: b<={b[0],b[15:1]}; fl<=b[0].
- Op bits are sampled on the same edge as shift_en; changing them between steps is legal and takes effect on the next step.
- steps increments on each accepted shift and saturates at all-ones; there is no wrap.
- Reset asserted mid-sequence forces the reset values immediately. After release, no shift happens until the next shift_en.
- X/Z on any strobe is a bench error; the RTL need not define behaviour for it.

Test Plan:
- Reset, then load 0x1234 -> b=0x1234, fl=0, steps=0; nread_alu_b=0 -> ibus_oe=1, ibus_out=0x1234.
- nstart, op 100, load 0x8001, 1 shift_en -> b=0x0002, fl=1; 2nd shift_en -> b=0x0005, fl=0, steps=2.
- nstart, op 011, load 0x8000, 15 shift_en -> b=0xFFFF, fl=0, steps=15.
- nstart, op 110, load 0xC003, 4 shift_en -> b=0x003C, fl=0. Op 111 from 0x0001, 1 step -> b=0x8000, fl=1.
- Load 0x00FF with shift_en high in the same cycle -> b=0x00FF, steps unchanged, collide pulses 1 cycle. Separately, 40 shifts -> steps=31 (saturated).
- Reset mid-ROL after 3 steps -> b=0, fl=0, steps=0 asynchronously; shift_en held during reset -> no change.

Source files
------------

// File: rtl/alu_portb_sr_if.sv
// Bus bundle for the ALU Port B shift register: IBus load/read path,
// SRU shift strobes and operation bits, and the register's observable state.
interface alu_portb_sr_if #(
    parameter int WIDTH = 16,
    parameter int CNTW  = 5
) ();

    logic [WIDTH-1:0] ibus_in;
    logic             nwrite_alu;
    logic             nstart;
    logic             shift_en;
    logic             op_rotate;
    logic             op_arithmetic;
    logic             op_right;
    logic             nread_alu_b;

    logic [WIDTH-1:0] b;
    logic             fl;
    logic [WIDTH-1:0] ibus_out;
    logic             ibus_oe;
    logic [CNTW-1:0]  steps;
    logic             collide;

    // Microcode/SRU side: drives strobes and data, observes the register
    modport master (
        output ibus_in, nwrite_alu, nstart, shift_en,
               op_rotate, op_arithmetic, op_right, nread_alu_b,
        input  b, fl, ibus_out, ibus_oe, steps, collide
    );

    // Port B register side
    modport slave (
        input  ibus_in, nwrite_alu, nstart, shift_en,
               op_rotate, op_arithmetic, op_right, nread_alu_b,
        output b, fl, ibus_out, ibus_oe, steps, collide
    );

endinterface

// File: rtl/alu_portb_sr.sv
// ALU Port B register with L (link) flag, built as a clocked shift register.
// Loaded from the IBus, shifted/rotated one bit per SRU strobe, read back
// onto the IBus. Load beats start beats shift on any given edge; a shift
// strobe that loses to load or start is dropped and flagged on collide.
module alu_portb_sr #(
    parameter int WIDTH = 16,
    parameter int CNTW  = 5
) (
    input  logic          clk2,
    input  logic          reset,
    alu_portb_sr_if.slave bus
);

    // Operation code as {rotate, arithmetic, right}
    typedef enum logic [2:0] {
        OP_SHL    = 3'b000,
        OP_SHR    = 3'b001,
        OP_SHL_A  = 3'b010,
        OP_ASR    = 3'b011,
        OP_ROL_L  = 3'b100,
        OP_ROR_L  = 3'b101,
        OP_ROL    = 3'b110,
        OP_ROR    = 3'b111
    } shift_op_e;

    localparam logic [CNTW-1:0] STEPS_MAX = '1;
    localparam logic [CNTW-1:0] STEPS_ONE = {{(CNTW-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] b_q;
    logic             fl_q;
    logic [CNTW-1:0]  steps_q;
    logic             collide_q;

    logic             load_req;
    logic             start_req;
    logic             shift_ok;
    shift_op_e        op;
    logic [WIDTH-1:0] b_shifted;
    logic             fl_shifted;

    assign load_req  = ~bus.nwrite_alu;
    assign start_req = ~bus.nstart;
    assign shift_ok  = bus.shift_en & ~load_req & ~start_req;
    assign op        = shift_op_e'({bus.op_rotate, bus.op_arithmetic, bus.op_right});

    // One shift step: new B and L computed from the current B, L and op bits
    always_comb begin
        b_shifted  = b_q;
        fl_shifted = fl_q;
        unique case (op)
            OP_SHL, OP_SHL_A: begin
                b_shifted  = {b_q[WIDTH-2:0], 1'b0};
                fl_shifted = b_q[WIDTH-1];
            end
            OP_SHR: begin
                b_shifted  = {1'b0, b_q[WIDTH-1:1]};
                fl_shifted = b_q[0];
            end
            OP_ASR: begin
                b_shifted  = {b_q[WIDTH-1], b_q[WIDTH-1:1]};
                fl_shifted = b_q[0];
            end
            OP_ROL_L: begin
                b_shifted  = {b_q[WIDTH-2:0], fl_q};
                fl_shifted = b_q[WIDTH-1];
            end
            OP_ROR_L: begin
                b_shifted  = {fl_q, b_q[WIDTH-1:1]};
                fl_shifted = b_q[0];
            end
            OP_ROL: begin
                b_shifted  = {b_q[WIDTH-2:0], b_q[WIDTH-1]};
                fl_shifted = b_q[WIDTH-1];
            end
            OP_ROR: begin
                b_shifted  = {b_q[0], b_q[WIDTH-1:1]};
                fl_shifted = b_q[0];
            end
            default: begin
                b_shifted  = b_q;
                fl_shifted = fl_q;
            end
        endcase
    end

    // B register: IBus load wins, otherwise an accepted shift step
    always_ff @(posedge clk2 or posedge reset) begin
        if (reset) begin
            b_q <= '0;
        end else if (load_req) begin
            b_q <= bus.ibus_in;
        end else if (shift_ok) begin
            b_q <= b_shifted;
        end
    end

    // L flag: cleared by start, otherwise takes the bit shifted out
    always_ff @(posedge clk2 or posedge reset) begin
        if (reset) begin
            fl_q <= 1'b0;
        end else if (start_req) begin
            fl_q <= 1'b0;
        end else if (shift_ok) begin
            fl_q <= fl_shifted;
        end
    end

    // Step counter: cleared by start, counts accepted shifts, sticks at all-ones
    always_ff @(posedge clk2 or posedge reset) begin
        if (reset) begin
            steps_q <= '0;
        end else if (start_req) begin
            steps_q <= '0;
        end else if (shift_ok && (steps_q != STEPS_MAX)) begin
            steps_q <= steps_q + STEPS_ONE;
        end
    end

    // Collision pulse: a shift strobe arrived while load or start owned the edge
    always_ff @(posedge clk2 or posedge reset) begin
        if (reset) begin
            collide_q <= 1'b0;
        end else begin
            collide_q <= bus.shift_en & (load_req | start_req);
        end
    end

    assign bus.b        = b_q;
    assign bus.fl       = fl_q;
    assign bus.steps    = steps_q;
    assign bus.collide  = collide_q;
    assign bus.ibus_out = b_q;
    assign bus.ibus_oe  = ~bus.nread_alu_b;

endmodule

// File: tb/tb_alu_portb_sr.sv
// Testbench for alu_portb_sr: directed scenarios plus a randomized run,
// all checked against a behavioural model of Port B and the L flag.
module tb_alu_portb_sr;

    localparam int WIDTH = 16;
    localparam int CNTW  = 5;

    logic clk2  = 1'b0;
    logic reset = 1'b1;

    int checks   = 0;
    int failures = 0;

    logic [15:0] mB       = '0;
    logic        mFl      = 1'b0;
    int          mSteps   = 0;
    logic        mCollide = 1'b0;

    alu_portb_sr_if #(.WIDTH(WIDTH), .CNTW(CNTW)) bus ();

    alu_portb_sr #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
        .clk2  (clk2),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock
    always #5 clk2 = ~clk2;

    // Reference model for one clock edge, written from the operation rules
    task automatic modelEdge(input logic nw, input logic ns, input logic se,
                             input logic [2:0] op, input logic [15:0] d);
        logic        load;
        logic        start;
        logic [16:0] v;
        load     = !nw;
        start    = !ns;
        mCollide = se && (load || start);
        if (se && !load && !start) begin
            if (op[2] && !op[1]) begin
                v = {mFl, mB};
                if (op[0]) v = (v >> 1) | (v << 16);
                else       v = (v << 1) | (v >> 16);
                mFl = v[16];
                mB  = v[15:0];
            end else if (op[2]) begin
                if (op[0]) begin
                    mFl = mB[0];
                    mB  = (mB >> 1) | (mB << 15);
                end else begin
                    mFl = mB[15];
                    mB  = (mB << 1) | (mB >> 15);
                end
            end else if (op[0]) begin
                mFl = mB[0];
                mB  = op[1] ? ((mB >> 1) | (mB & 16'h8000)) : (mB >> 1);
            end else begin
                mFl = mB[15];
                mB  = mB << 1;
            end
            if (mSteps < 31) mSteps = mSteps + 1;
        end
        if (load)  mB = d;
        if (start) begin
            mFl    = 1'b0;
            mSteps = 0;
        end
    endtask

    task automatic modelReset();
        mB       = '0;
        mFl      = 1'b0;
        mSteps   = 0;
        mCollide = 1'b0;
    endtask

    // Single comparison with counting and reporting
    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every DUT output against the model
    task automatic checkOutput(input string tag);
        checkVal({tag, ".b"},        {16'h0, bus.b},          {16'h0, mB});
        checkVal({tag, ".fl"},       {31'h0, bus.fl},         {31'h0, mFl});
        checkVal({tag, ".steps"},    {27'h0, bus.steps},      mSteps[31:0]);
        checkVal({tag, ".collide"},  {31'h0, bus.collide},    {31'h0, mCollide});
        checkVal({tag, ".ibus_out"}, {16'h0, bus.ibus_out},   {16'h0, mB});
        checkVal({tag, ".ibus_oe"},  {31'h0, bus.ibus_oe},    {31'h0, !bus.nread_alu_b});
    endtask

    // Drive one cycle of strobes, clock it, update the model, settle
    task automatic applyStimulus(input logic nw, input logic ns, input logic se,
                                 input logic [2:0] op, input logic [15:0] d);
        bus.nwrite_alu    = nw;
        bus.nstart        = ns;
        bus.shift_en      = se;
        bus.op_rotate     = op[2];
        bus.op_arithmetic = op[1];
        bus.op_right      = op[0];
        bus.ibus_in       = d;
        @(posedge clk2);
        if (!reset) modelEdge(nw, ns, se, op, d);
        #1;
    endtask

    task automatic doLoad(input logic [15:0] d);
        applyStimulus(1'b0, 1'b1, 1'b0, 3'b000, d);
    endtask

    task automatic doStart(input logic [2:0] op);
        applyStimulus(1'b1, 1'b0, 1'b0, op, 16'h0);
    endtask

    task automatic doShift(input logic [2:0] op);
        applyStimulus(1'b1, 1'b1, 1'b1, op, 16'h0);
    endtask

    task automatic idle();
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b000, 16'h0);
    endtask

    initial begin
        bus.ibus_in       = '0;
        bus.nwrite_alu    = 1'b1;
        bus.nstart        = 1'b1;
        bus.shift_en      = 1'b0;
        bus.op_rotate     = 1'b0;
        bus.op_arithmetic = 1'b0;
        bus.op_right      = 1'b0;
        bus.nread_alu_b   = 1'b1;

        // Reset with a shift strobe held, which must be ignored
        bus.shift_en = 1'b1;
        repeat (3) @(posedge clk2);
        #2;
        bus.shift_en = 1'b0;
        reset = 1'b0;
        #1;
        modelReset();
        checkOutput("reset");
        @(posedge clk2);
        #1;

        // Load and read back
        doLoad(16'h1234);
        bus.nread_alu_b = 1'b0;
        #1;
        checkOutput("load1234");
        checkVal("load1234.const", {16'h0, bus.ibus_out}, 32'h1234);
        bus.nread_alu_b = 1'b1;

        // ROL through L
        doStart(3'b100);
        doLoad(16'h8001);
        doShift(3'b100);
        checkOutput("roll1");
        checkVal("roll1.const", {15'h0, bus.fl, bus.b}, 32'h10002);
        doShift(3'b100);
        checkOutput("roll2");
        checkVal("roll2.const", {10'h0, bus.steps, bus.fl, bus.b}, {10'h0, 5'd2, 1'b0, 16'h0005});

        // ASR x15
        doStart(3'b011);
        doLoad(16'h8000);
        for (int i = 0; i < 15; i++) doShift(3'b011);
        checkOutput("asr15");
        checkVal("asr15.const", {10'h0, bus.steps, bus.fl, bus.b}, {10'h0, 5'd15, 1'b0, 16'hFFFF});

        // 16-bit rotates
        doStart(3'b110);
        doLoad(16'hC003);
        for (int i = 0; i < 4; i++) doShift(3'b110);
        checkOutput("rol16");
        checkVal("rol16.const", {15'h0, bus.fl, bus.b}, 32'h0003C);
        doLoad(16'h0001);
        doShift(3'b111);
        checkOutput("ror16");
        checkVal("ror16.const", {15'h0, bus.fl, bus.b}, 32'h18000);

        // Load colliding with a shift strobe
        doStart(3'b000);
        doShift(3'b001);
        applyStimulus(1'b0, 1'b1, 1'b1, 3'b001, 16'h00FF);
        checkOutput("collide");
        checkVal("collide.const", {15'h0, bus.collide, bus.b}, 32'h100FF);
        idle();
        checkOutput("collide_end");

        // Start colliding with a shift strobe
        doShift(3'b000);
        applyStimulus(1'b1, 1'b0, 1'b1, 3'b000, 16'h0);
        checkOutput("start_collide");

        // Saturation of the step counter
        doStart(3'b110);
        for (int i = 0; i < 40; i++) doShift(3'b110);
        checkOutput("saturate");
        checkVal("saturate.const", {27'h0, bus.steps}, 32'd31);

        // Reset in the middle of a ROL sequence
        doStart(3'b100);
        doLoad(16'hA5C3);
        for (int i = 0; i < 3; i++) doShift(3'b100);
        checkOutput("pre_reset");
        bus.shift_en = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        modelReset();
        checkOutput("async_reset");
        repeat (2) @(posedge clk2);
        #1;
        checkOutput("reset_hold");
        bus.shift_en = 1'b0;
        #2;
        reset = 1'b0;
        @(posedge clk2);
        #1;
        checkOutput("post_reset");

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            logic        nw;
            logic        ns;
            logic        se;
            logic [2:0]  op;
            logic [15:0] d;
            nw = ($urandom_range(0, 5) != 0);
            ns = ($urandom_range(0, 11) != 0);
            se = ($urandom_range(0, 3) != 0);
            op = 3'($urandom_range(0, 7));
            d  = 16'($urandom);
            bus.nread_alu_b = 1'($urandom_range(0, 1));
            applyStimulus(nw, ns, se, op, d);
            checkOutput("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against a hung run
    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] timeout");
    end

endmodule
